// File: rtl/snake_pkg.sv
// Shared snake types: direction codes, default grid geometry, body tracer FSM encoding.
// Pure declarations, no logic or latency of its own.
package snake_pkg;

  localparam int DEF_GRID_W = 32;
  localparam int DEF_GRID_H = 24;
  localparam int DEF_CW     = 6;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_STEP = 2'd2
  } trace_state_t;

endpackage

// File: rtl/dir_unstep.sv
// Reverse-steps a grid cell against a recorded move, with modular wrap at the grid edges.
// Combinational, zero latency; no flow control.
module dir_unstep
  import snake_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  parameter int CW     = DEF_CW
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [2:0]    dir,
  output logic [CW-1:0] prev_x,
  output logic [CW-1:0] prev_y
);

  localparam logic [CW-1:0] X_MAX = CW'(GRID_W - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(GRID_H - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  // Codes outside UP/DOWN/LEFT/RIGHT leave the cell unchanged.
  always_comb begin
    prev_x = x;
    prev_y = y;
    case (dir)
      DIR_UP:    prev_y = (y == Y_MAX) ? '0 : y + ONE;
      DIR_DOWN:  prev_y = (y == '0) ? Y_MAX : y - ONE;
      DIR_LEFT:  prev_x = (x == X_MAX) ? '0 : x + ONE;
      DIR_RIGHT: prev_x = (x == '0) ? X_MAX : x - ONE;
      default:   ;
    endcase
  end

endmodule

// File: rtl/body_tracer.sv
// Walks the move history from the head and emits one body segment every 2 cycles, all outputs registered.
// No backpressure: start is ignored while busy. BODY_TRACER_HIT_EN adds the sticky probe-collision flag.
module body_tracer
  import snake_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  parameter int CW     = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] head_x,
  input  logic [CW-1:0] head_y,
  input  logic [6:0]    len,
  input  logic [2:0]    dir_in,
  output logic [5:0]    pos,
  output logic          seg_valid,
  output logic [CW-1:0] seg_x,
  output logic [CW-1:0] seg_y,
  output logic [5:0]    seg_idx,
  output logic          busy,
  output logic          done,
  input  logic [CW-1:0] probe_x,
  input  logic [CW-1:0] probe_y,
  output logic          hit
);

  trace_state_t  state, state_nxt;
  logic [CW-1:0] cur_x, cur_y, cur_x_nxt, cur_y_nxt;
  logic [CW-1:0] step_x, step_y;
  logic [5:0]    idx, idx_nxt, last_idx, last_idx_nxt, last_in;
  logic [5:0]    pos_nxt, seg_idx_nxt;
  logic [CW-1:0] seg_x_nxt, seg_y_nxt;
  logic          seg_valid_nxt, busy_nxt, done_nxt;

  dir_unstep #(.GRID_W(GRID_W), .GRID_H(GRID_H), .CW(CW)) u_unstep (
    .x      (cur_x),
    .y      (cur_y),
    .dir    (dir_in),
    .prev_x (step_x),
    .prev_y (step_y)
  );

  // Stored as the index of the final segment: len 0 behaves as 1, anything past 64 as 64.
  always_comb begin
    if (len == 7'd0)       last_in = 6'd0;
    else if (len > 7'd64)  last_in = 6'd63;
    else                   last_in = 6'(len - 7'd1);
  end

  always_comb begin
    state_nxt     = state;
    cur_x_nxt     = cur_x;
    cur_y_nxt     = cur_y;
    idx_nxt       = idx;
    last_idx_nxt  = last_idx;
    pos_nxt       = pos;
    seg_valid_nxt = 1'b0;
    seg_x_nxt     = seg_x;
    seg_y_nxt     = seg_y;
    seg_idx_nxt   = seg_idx;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          cur_x_nxt     = head_x;
          cur_y_nxt     = head_y;
          idx_nxt       = 6'd1;
          last_idx_nxt  = last_in;
          pos_nxt       = 6'd0;
          seg_valid_nxt = 1'b1;
          seg_x_nxt     = head_x;
          seg_y_nxt     = head_y;
          seg_idx_nxt   = 6'd0;
          busy_nxt      = 1'b1;
          if (last_in == 6'd0) done_nxt  = 1'b1;
          else                 state_nxt = ST_WAIT;
        end
      end
      // One idle cycle while the history register answers the pos read.
      ST_WAIT: state_nxt = ST_STEP;
      ST_STEP: begin
        cur_x_nxt     = step_x;
        cur_y_nxt     = step_y;
        seg_valid_nxt = 1'b1;
        seg_x_nxt     = step_x;
        seg_y_nxt     = step_y;
        seg_idx_nxt   = idx;
        pos_nxt       = idx;
        idx_nxt       = 6'(idx + 6'd1);
        if (idx == last_idx) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cur_x     <= '0;
      cur_y     <= '0;
      idx       <= '0;
      last_idx  <= '0;
      pos       <= '0;
      seg_valid <= 1'b0;
      seg_x     <= '0;
      seg_y     <= '0;
      seg_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_x     <= cur_x_nxt;
      cur_y     <= cur_y_nxt;
      idx       <= idx_nxt;
      last_idx  <= last_idx_nxt;
      pos       <= pos_nxt;
      seg_valid <= seg_valid_nxt;
      seg_x     <= seg_x_nxt;
      seg_y     <= seg_y_nxt;
      seg_idx   <= seg_idx_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

`ifdef BODY_TRACER_HIT_EN
  logic [CW-1:0] probe_x_q, probe_y_q;
  logic          hit_q;

  // Only STEP emits segments past the head, so the head never sets hit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      probe_x_q <= '0;
      probe_y_q <= '0;
      hit_q     <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      probe_x_q <= probe_x;
      probe_y_q <= probe_y;
      hit_q     <= 1'b0;
    end else if (state == ST_STEP && step_x == probe_x_q && step_y == probe_y_q) begin
      hit_q     <= 1'b1;
    end
  end

  assign hit = hit_q;
`else
  logic unused_probe;
  assign unused_probe = ^{probe_x, probe_y};
  assign hit = 1'b0;
`endif

endmodule
